// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the ROM address, assembles 1/2-byte
// instructions and issues them to execute over a valid/ready handshake.
module fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] opcode,
  output logic [DATA_W-1:0] operand,
  output logic              has_operand,
  output logic              instr_illegal,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target
);

  typedef enum logic [2:0] {
    F_ADDR,
    F_OPC,
    O_ADDR,
    O_DATA,
    ISSUE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] pc;
  logic              two_byte;
  logic              alu_op;
  logic              handshake;

  assign mem_address = pc;
  assign instr_valid = (state == ISSUE);
  assign handshake   = instr_valid && instr_ready;

  // Opcode class is decoded straight off the ROM bus during F_OPC.
  always_comb begin
    two_byte = 1'b0;
    alu_op   = 1'b0;
    unique case (1'b1)
      (mem_data_in >= 8'h10 && mem_data_in <= 8'h15): two_byte = 1'b1;
      (mem_data_in >= 8'h30 && mem_data_in <= 8'h38): two_byte = 1'b1;
      (mem_data_in >= 8'h20 && mem_data_in <= 8'h27): alu_op   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= F_ADDR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      F_ADDR: state_nxt = F_OPC;
      F_OPC:  state_nxt = two_byte ? O_ADDR : ISSUE;
      O_ADDR: state_nxt = O_DATA;
      O_DATA: state_nxt = ISSUE;
      ISSUE:  state_nxt = handshake ? F_ADDR : ISSUE;
      default: state_nxt = F_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      opcode        <= '0;
      operand       <= '0;
      instr_pc      <= '0;
      has_operand   <= 1'b0;
      instr_illegal <= 1'b0;
    end else begin
      unique case (state)
        F_OPC: begin
          opcode        <= mem_data_in;
          instr_pc      <= pc;
          pc            <= pc + ADDR_W'(1);
          has_operand   <= two_byte;
          instr_illegal <= !two_byte && !alu_op;
          if (!two_byte) begin
            operand <= '0;
          end
        end
        O_DATA: begin
          operand <= mem_data_in;
          pc      <= pc + ADDR_W'(1);
        end
        ISSUE: begin
          if (handshake && branch_taken) begin
            pc <= branch_target;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM model, expected-instruction
// scoreboard and immediate-assertion checks.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] mem_address;
  logic [7:0] mem_data_in;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic       has_operand;
  logic       instr_illegal;
  logic [7:0] instr_pc;
  logic       branch_taken;
  logic [7:0] branch_target;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .mem_address   (mem_address),
    .mem_data_in   (mem_data_in),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .opcode        (opcode),
    .operand       (operand),
    .has_operand   (has_operand),
    .instr_illegal (instr_illegal),
    .instr_pc      (instr_pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [256];

  always @(posedge clk) mem_data_in <= rom[mem_address];

  typedef struct {
    logic [7:0] opc;
    logic [7:0] opr;
    logic       has;
    logic       ill;
    logic [7:0] pc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [7:0] opc, logic [7:0] opr,
                      logic has, logic ill, logic [7:0] pc);
    exp_t e;
    e.opc = opc;
    e.opr = opr;
    e.has = has;
    e.ill = ill;
    e.pc  = pc;
    sb.push_back(e);
  endtask

  task automatic expect_issue(string tag);
    int   n = 0;
    exp_t e;
    while (instr_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, " valid"}, 32'(instr_valid), 32'd1);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s sb: observed empty queue expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, " opcode"},  32'(opcode),        32'(e.opc));
      chk({tag, " operand"}, 32'(operand),       32'(e.opr));
      chk({tag, " has_op"},  32'(has_operand),   32'(e.has));
      chk({tag, " illegal"}, 32'(instr_illegal), 32'(e.ill));
      chk({tag, " pc"},      32'(instr_pc),      32'(e.pc));
    end
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, " valid"},   32'(instr_valid),   32'd0);
    chk({tag, " addr"},    32'(mem_address),   32'h00);
    chk({tag, " opcode"},  32'(opcode),        32'h00);
    chk({tag, " operand"}, 32'(operand),       32'h00);
    chk({tag, " pc"},      32'(instr_pc),      32'h00);
    chk({tag, " has_op"},  32'(has_operand),   32'd0);
    chk({tag, " illegal"}, 32'(instr_illegal), 32'd0);
  endtask

  task automatic do_reset(string tag);
    reset        = 1'b1;
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    tick();
    tick();
    chk_reset_state(tag);
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    reset         = 1'b1;
    instr_ready   = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = 8'hEE;

    // Straight-line program with ready tied high
    rom[0] = 8'h10; rom[1] = 8'h0F; rom[2] = 8'h12;
    rom[3] = 8'h0F; rom[4] = 8'h20;
    push(8'h10, 8'h0F, 1'b1, 1'b0, 8'h00);
    push(8'h12, 8'h0F, 1'b1, 1'b0, 8'h02);
    push(8'h20, 8'h00, 1'b0, 1'b0, 8'h04);
    do_reset("t1 rst");
    chk("t1 first addr", 32'(mem_address), 32'h00);
    instr_ready = 1'b1;
    expect_issue("t1a");
    chk("t1a cycle", 32'(cyc), 32'd4);
    tick();
    expect_issue("t1b");
    chk("t1b cycle", 32'(cyc), 32'd9);
    tick();
    expect_issue("t1c");
    chk("t1c cycle", 32'(cyc), 32'd12);
    tick();

    // Backpressure, with a stray branch request while stalled
    push(8'h10, 8'h0F, 1'b1, 1'b0, 8'h00);
    push(8'h12, 8'h0F, 1'b1, 1'b0, 8'h02);
    push(8'h20, 8'h00, 1'b0, 1'b0, 8'h04);
    do_reset("t2 rst");
    instr_ready = 1'b1;
    expect_issue("t2a");
    tick();
    instr_ready = 1'b0;
    expect_issue("t2b");
    branch_taken  = 1'b1;
    branch_target = 8'h80;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t2 stall valid",   32'(instr_valid), 32'd1);
      chk("t2 stall opcode",  32'(opcode),      32'h12);
      chk("t2 stall operand", 32'(operand),     32'h0F);
      chk("t2 stall pc",      32'(instr_pc),    32'h02);
      chk("t2 stall addr",    32'(mem_address), 32'h04);
    end
    branch_taken = 1'b0;
    instr_ready  = 1'b1;
    tick();
    chk("t2 accept valid", 32'(instr_valid), 32'd0);
    chk("t2 accept addr",  32'(mem_address), 32'h04);
    expect_issue("t2c");
    tick();

    // Branch on handshake; branch_taken high earlier is ignored
    rom[0] = 8'h30; rom[1] = 8'h40; rom[8'h40] = 8'h20;
    push(8'h30, 8'h40, 1'b1, 1'b0, 8'h00);
    push(8'h20, 8'h00, 1'b0, 1'b0, 8'h40);
    do_reset("t3 rst");
    instr_ready   = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 8'h40;
    expect_issue("t3a");
    tick();
    chk("t3 redirect addr",  32'(mem_address), 32'h40);
    chk("t3 redirect valid", 32'(instr_valid), 32'd0);
    branch_taken = 1'b0;
    expect_issue("t3b");
    tick();

    // PC wrap across 8'hFF during an operand fetch
    rom[0] = 8'h20; rom[8'hFE] = 8'h10; rom[8'hFF] = 8'hAA;
    push(8'h20, 8'h00, 1'b0, 1'b0, 8'h00);
    push(8'h10, 8'hAA, 1'b1, 1'b0, 8'hFE);
    push(8'h20, 8'h00, 1'b0, 1'b0, 8'h00);
    do_reset("t4 rst");
    instr_ready = 1'b1;
    expect_issue("t4a");
    branch_taken  = 1'b1;
    branch_target = 8'hFE;
    tick();
    branch_taken = 1'b0;
    chk("t4 branch addr", 32'(mem_address), 32'hFE);
    expect_issue("t4b");
    tick();
    chk("t4 wrap addr", 32'(mem_address), 32'h00);
    expect_issue("t4c");
    tick();

    // Illegal opcode is issued as a 1-byte instruction
    rom[0] = 8'h7E; rom[1] = 8'h20;
    push(8'h7E, 8'h00, 1'b0, 1'b1, 8'h00);
    push(8'h20, 8'h00, 1'b0, 1'b0, 8'h01);
    do_reset("t5 rst");
    instr_ready = 1'b1;
    expect_issue("t5a");
    chk("t5a cycle", 32'(cyc), 32'd2);
    tick();
    chk("t5 next addr", 32'(mem_address), 32'h01);
    expect_issue("t5b");
    tick();

    // Reset in O_DATA, then in ISSUE against a branching handshake
    rom[0] = 8'h10; rom[1] = 8'h0F; rom[2] = 8'h20;
    push(8'h10, 8'h0F, 1'b1, 1'b0, 8'h00);
    do_reset("t6 rst");
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_reset_state("t6 odata rst");
    reset = 1'b0;
    cyc   = 0;
    expect_issue("t6a");
    chk("t6a cycle", 32'(cyc), 32'd4);
    instr_ready   = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 8'h40;
    reset         = 1'b1;
    tick();
    chk_reset_state("t6 issue rst");
    reset        = 1'b0;
    branch_taken = 1'b0;
    cyc          = 0;
    push(8'h10, 8'h0F, 1'b1, 1'b0, 8'h00);
    expect_issue("t6b");
    chk("t6b cycle", 32'(cyc), 32'd4);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
